// File: rtl/ofifo_elastic.sv
// Opaque elastic FIFO: registered valid/data/ready on both sides.
// Circular buffer with modulo-NUM_SLOTS pointers and an occupancy counter.
module ofifo_elastic #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            ins,
  input  logic                             ins_valid,
  output logic                             ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic                             outs_valid,
  input  logic                             outs_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   count
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_SLOTS];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty, full;
  logic                  push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_SLOTS - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(NUM_SLOTS));

  // Handshake outputs depend only on registered occupancy.
  assign ins_ready  = ~full;
  assign outs_valid = ~empty;
  assign outs       = mem_q[rd_ptr_q];
  assign count      = count_q;

  assign push = ins_valid & ~full;
  assign pop  = outs_ready & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = ins;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ofifo_elastic.sv
// Directed and randomized checks for ofifo_elastic.
// Two instances: 4x32 for directed steps, 3x8 for the random scoreboard.
module tb_ofifo_elastic;

  logic        clk;
  logic        rst;

  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] outs;
  logic        outs_valid;
  logic        outs_ready;
  logic [2:0]  count;

  logic [7:0]  b_ins;
  logic        b_ins_valid;
  logic        b_ins_ready;
  logic [7:0]  b_outs;
  logic        b_outs_valid;
  logic        b_outs_ready;
  logic [1:0]  b_count;

  int checks;
  int errors;

  ofifo_elastic #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_a (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .count      (count)
  );

  ofifo_elastic #(.DATA_WIDTH(8), .NUM_SLOTS(3)) u_b (
    .clk        (clk),
    .rst        (rst),
    .ins        (b_ins),
    .ins_valid  (b_ins_valid),
    .ins_ready  (b_ins_ready),
    .outs       (b_outs),
    .outs_valid (b_outs_valid),
    .outs_ready (b_outs_ready),
    .count      (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] drain [4];
    logic [7:0]  q [$];
    logic        psh, pp;

    checks = 0;
    errors = 0;
    rst = 1'b0;
    ins = '0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    b_ins = '0;
    b_ins_valid = 1'b0;
    b_outs_ready = 1'b0;
    #1;
    chk("rst_outs_valid", outs_valid, 0);
    chk("rst_ins_ready", ins_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_outs", outs, 0);
    tick();
    rst = 1'b1;

    // Load three tokens, then reset mid-stream.
    ins_valid = 1'b1;
    ins = 32'h11; tick();
    ins = 32'h22; tick();
    ins = 32'h33; tick();
    chk("mid_count3", count, 3);
    ins_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", outs_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", ins_ready, 1);
    chk("mid_rst_outs", outs, 0);
    tick();
    rst = 1'b1;
    ins = 32'hA5;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    chk("a5_valid", outs_valid, 1);
    chk("a5_outs", outs, 32'hA5);
    chk("a5_count", count, 1);
    outs_ready = 1'b1;
    tick();
    outs_ready = 1'b0;
    chk("a5_drain_count", count, 0);
    chk("a5_drain_valid", outs_valid, 0);

    // Fill with consumer stalled.
    ins_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ins = 32'(i);
      tick();
      chk("fill_count", count, 32'(i));
      chk("fill_ready", ins_ready, (i < 4) ? 1 : 0);
    end
    chk("fill_head", outs, 32'h1);
    ins = 32'h99;
    tick();
    chk("full_count", count, 4);
    chk("full_head", outs, 32'h1);

    // Toggle inputs mid-cycle; registered outputs must not move.
    outs_ready = 1'b1;
    ins = 32'h77;
    #1;
    chk("iso_ready", ins_ready, 0);
    chk("iso_outs", outs, 32'h1);
    chk("iso_valid", outs_valid, 1);
    ins_valid = 1'b0;
    tick();
    outs_ready = 1'b0;
    chk("pop_count", count, 3);
    chk("pop_head", outs, 32'h2);
    chk("pop_ready", ins_ready, 1);
    ins = 32'h5;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    chk("wrap_count", count, 4);
    drain[0] = 32'h2;
    drain[1] = 32'h3;
    drain[2] = 32'h4;
    drain[3] = 32'h5;
    outs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", outs_valid, 1);
      chk("drain_outs", outs, drain[i]);
      tick();
    end
    outs_ready = 1'b0;
    chk("drain_empty", outs_valid, 0);
    chk("drain_count", count, 0);

    // Streaming at one token per cycle.
    ins_valid = 1'b1;
    outs_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ins = 32'(i);
      tick();
      chk("stream_outs", outs, 32'(i));
      chk("stream_count", count, 1);
    end
    ins_valid = 1'b0;
    tick();
    outs_ready = 1'b0;
    chk("stream_end", count, 0);

    // Random stalls on the 3-slot instance against a queue model.
    for (int c = 0; c < 10000; c++) begin
      b_ins_valid = 1'($urandom_range(0, 1));
      b_outs_ready = 1'($urandom_range(0, 1));
      b_ins = 8'($urandom);
      psh = b_ins_valid && (q.size() < 3);
      pp  = b_outs_ready && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(b_ins);
      tick();
      chk("rnd_count", b_count, 32'(q.size()));
      chk("rnd_valid", b_outs_valid, (q.size() > 0) ? 1 : 0);
      chk("rnd_ready", b_ins_ready, (q.size() < 3) ? 1 : 0);
      if (q.size() > 0) chk("rnd_outs", b_outs, q[0]);
    end
    b_ins_valid = 1'b0;
    b_outs_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
